// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the two-digit seven-segment display driver.
// All segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package bcd_disp_pkg;

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } dig_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] DIGIT_PAT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/bcd_7seg_display_mux_if.sv
// Digit inputs from the BCD converter and the display-side outputs.
// master = producer of digits / consumer of display lines, slave = display driver.
interface bcd_7seg_display_mux_if;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;
  logic       bcd_err;

  modport master (
    output ones, tens,
    input  seg, an, frame_tick, bcd_err
  );

  modport slave (
    input  ones, tens,
    output seg, an, frame_tick, bcd_err
  );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; values above 9 show a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup for valid digits, dash for 10..15
  always_comb begin
    if (bcd > 4'd9) seg = SEG_DASH;
    else            seg = DIGIT_PAT[bcd];
  end

endmodule

// File: rtl/bcd_7seg_display_mux.sv
// Two-digit time-multiplexed seven-segment driver.
// Digits are latched once per frame (ones phase + tens phase) so the display never
// tears; seg/an are registered from next-state values so they never skew.
// Optional build macro: BCD_DISP_LEADING_ZERO_BLANK_EN blanks a leading tens zero.
module bcd_7seg_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_7seg_display_mux_if.slave   bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  dig_state_t       state, state_nx;
  logic [CNT_W-1:0] refresh_cnt, cnt_nx;
  logic [3:0]       hold_ones, hold_tens;
  logic [3:0]       hold_ones_nx, hold_tens_nx;
  logic [3:0]       dec_in;
  logic [6:0]       dec_seg, seg_nx;
  logic             term, frame;

  logic [6:0]       seg_q;
  logic [1:0]       an_q;
  logic             frame_tick_q;
  logic             bcd_err_q;

  // Next-state, counter and hold-register values; digits sampled only at frame end
  always_comb begin
    term         = (refresh_cnt == CNT_LAST);
    frame        = term && (state == DIG_TENS);
    cnt_nx       = term ? '0 : refresh_cnt + 1'b1;
    state_nx     = state;
    if (term) state_nx = (state == DIG_ONES) ? DIG_TENS : DIG_ONES;
    hold_ones_nx = frame ? bus.ones : hold_ones;
    hold_tens_nx = frame ? bus.tens : hold_tens;
    dec_in       = (state_nx == DIG_ONES) ? hold_ones_nx : hold_tens_nx;
  end

  bcd_to_7seg u_dec (
    .bcd (dec_in),
    .seg (dec_seg)
  );

  // Segment value to load; optionally suppress a leading tens zero
  always_comb begin
    seg_nx = dec_seg;
`ifdef BCD_DISP_LEADING_ZERO_BLANK_EN
    if ((state_nx == DIG_TENS) && (hold_tens_nx == 4'd0)) seg_nx = SEG_BLANK;
`endif
  end

  // Digit FSM, refresh counter, hold registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DIG_ONES;
      refresh_cnt  <= '0;
      hold_ones    <= 4'd0;
      hold_tens    <= 4'd0;
      seg_q        <= DIGIT_PAT[0];
      an_q         <= AN_ONES;
      frame_tick_q <= 1'b0;
      bcd_err_q    <= 1'b0;
    end else begin
      state        <= state_nx;
      refresh_cnt  <= cnt_nx;
      hold_ones    <= hold_ones_nx;
      hold_tens    <= hold_tens_nx;
      seg_q        <= seg_nx;
      an_q         <= (state_nx == DIG_ONES) ? AN_ONES : AN_TENS;
      frame_tick_q <= frame;
      if (frame) bcd_err_q <= (bus.ones > 4'd9) | (bus.tens > 4'd9);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_bcd_7seg_display_mux.sv
// Directed bench for bcd_7seg_display_mux with REFRESH_DIV = 4.
module tb_bcd_7seg_display_mux;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bcd_7seg_display_mux_if bus ();

  bcd_7seg_display_mux #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (at falling edges) for frame_tick; returns number of cycles, 0 on timeout.
  task automatic wait_tick(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  // Check one 4-cycle digit phase starting at the current falling edge.
  task automatic check_phase(input string tag, input logic [6:0] s, input logic [1:0] a,
                             input logic first_tick, input logic err);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_seg"}, {25'd0, bus.seg}, {25'd0, s});
      chk({tag, "_an"},  {30'd0, bus.an},  {30'd0, a});
      chk({tag, "_ft"},  {31'd0, bus.frame_tick}, {31'd0, (i == 0) ? first_tick : 1'b0});
      chk({tag, "_err"}, {31'd0, bus.bcd_err}, {31'd0, err});
      @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_seg"}, {25'd0, bus.seg}, 32'h40);
    chk({tag, "_an"},  {30'd0, bus.an},  32'h2);
    chk({tag, "_ft"},  {31'd0, bus.frame_tick}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.bcd_err}, 32'd0);
  endtask

  initial begin
    int cyc;
    logic [6:0] lz_exp;
    n_tests = 0;
    n_fail  = 0;
`ifdef BCD_DISP_LEADING_ZERO_BLANK_EN
    lz_exp = 7'h7F;
`else
    lz_exp = 7'h40;
`endif

    // Reset asserted at time zero, checked before any clock edge
    rst      = 1'b1;
    bus.ones = 4'd3;
    bus.tens = 4'd1;
    #1;
    check_reset_vals("rst0");

    // Release reset at a falling edge; first frame lands 8 cycles later
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_tick(cyc);
    chk("first_tick_cyc", cyc, 32'd8);

    // Steady 13
    check_phase("steady_ones", 7'h30, 2'b10, 1'b1, 1'b0);
    check_phase("steady_tens", 7'h79, 2'b01, 1'b0, 1'b0);
    chk("steady_tick", {31'd0, bus.frame_tick}, 32'd1);

    // Mid-frame change of ones: invisible until the next frame
    bus.ones = 4'd5;
    check_phase("mid_ones", 7'h30, 2'b10, 1'b1, 1'b0);
    check_phase("mid_tens", 7'h79, 2'b01, 1'b0, 1'b0);
    chk("mid_new_tick", {31'd0, bus.frame_tick}, 32'd1);
    chk("mid_new_seg", {25'd0, bus.seg}, 32'h12);

    // Invalid ones digit
    bus.ones = 4'hB;
    check_phase("inv_pre_ones", 7'h12, 2'b10, 1'b1, 1'b0);
    check_phase("inv_pre_tens", 7'h79, 2'b01, 1'b0, 1'b0);
    check_phase("inv_ones", 7'h3F, 2'b10, 1'b1, 1'b1);
    bus.ones = 4'd2;
    check_phase("inv_tens", 7'h79, 2'b01, 1'b0, 1'b1);
    chk("inv_clr_err", {31'd0, bus.bcd_err}, 32'd0);
    chk("inv_clr_seg", {25'd0, bus.seg}, 32'h24);

    // Leading zero
    bus.tens = 4'd0;
    bus.ones = 4'd7;
    check_phase("lz_pre_ones", 7'h24, 2'b10, 1'b1, 1'b0);
    check_phase("lz_pre_tens", 7'h79, 2'b01, 1'b0, 1'b0);
    check_phase("lz_ones", 7'h78, 2'b10, 1'b1, 1'b0);
    check_phase("lz_tens", lz_exp, 2'b01, 1'b0, 1'b0);

    // Reset in the middle of the tens phase
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("mid_rst_pre_an", {30'd0, bus.an}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("mid_rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_seg", {25'd0, bus.seg}, 32'h40);
    chk("post_rst_an",  {30'd0, bus.an},  32'h2);
    wait_tick(cyc);
    chk("post_rst_tick_cyc", cyc, 32'd7);
    chk("post_rst_new_seg", {25'd0, bus.seg}, 32'h78);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_display_mux.md
# bcd_7seg_display_mux

Two-digit, time-multiplexed seven-segment display driver. It sits directly downstream of `binary_to_bcd_converter` and consumes that block's `ones`/`tens` BCD digits. It latches both digits once per refresh frame so the display never tears, and alternates the common-anode select between the two digits at a programmable rate. Segment and anode outputs are registered, active-low, and drive the board display directly.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit. Legal range is ≥ 2.
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `ones` input 4: BCD units digit from the converter.
- `tens` input 4: BCD tens digit from the converter.
- `seg` output 7: segment drive, active-low; `seg[0]`=a … `seg[6]`=g.
- `an` output 2: digit select, active-low; `an[0]`=ones digit, `an[1]`=tens digit.
- `frame_tick` output 1: one-cycle pulse on the cycle new digits are latched.
- `bcd_err` output 1: at least one latched digit is > 9; held for the whole frame.

## Operation
- **State machine:** two states, `DIG_ONES` and `DIG_TENS`.
- **Refresh counter:** `refresh_cnt` has width `$clog2(REFRESH_DIV)` and counts 0 … `REFRESH_DIV`-1, then wraps to 0.
- **Digit switch:** at terminal count (`REFRESH_DIV`-1), the state toggles.
- **Frame boundary:** terminal count while in `DIG_TENS`. At the frame boundary:
  - `hold_ones` ← `ones` and `hold_tens` ← `tens`.
  - `bcd_err` ← (`ones` > 9) | (`tens` > 9).
  - `frame_tick` = 1 for that cycle.
- **Input sampling:** `ones`/`tens` are sampled only at the frame boundary. Changes at any other time are invisible until the next frame.
- **Decode:** the active digit comes from the hold registers.
  - Values 0–9 use the standard pattern.
  - Values 10–15 display a dash, pattern 7'h3F (g on only).
- **Anode select:** `an` = 2'b10 in `DIG_ONES` and 2'b01 in `DIG_TENS`. Exactly one anode is low at all times outside reset.
- **Consistency:** `seg` and `an` are loaded from the decode of the next-state and next-hold values. They are therefore always consistent with the state register, with no one-cycle segment/anode skew.
- **Reset values:**
  - State `DIG_ONES`, `refresh_cnt` = 0, `hold_ones` = `hold_tens` = 0.
  - `seg` = 7'h40 (digit 0), `an` = 2'b10, `frame_tick` = 0, `bcd_err` = 0.
- **Reset mid-frame:** outputs go to their reset values immediately (asynchronously). The next frame boundary occurs `2*REFRESH_DIV` cycles after reset deassertion.

## Timing
- **Digit period:** `REFRESH_DIV` cycles. **Frame period:** `2*REFRESH_DIV` cycles.
- **Input-to-display latency:** `ones`/`tens` stable before a frame boundary appear on `seg` in the very next cycle (`DIG_ONES`, ones digit). The tens digit appears `REFRESH_DIV` cycles later.
- **Worst-case latency:** an input change appears after at most `2*REFRESH_DIV`+1 cycles.
- **`frame_tick` coincidence:** `frame_tick` is high in the same cycle that `an` returns to 2'b10 on the frame boundary. It is never high for two consecutive cycles.
- **`bcd_err` timing:** `bcd_err` changes only at frame boundaries and at reset.

## Configuration
- **Macro:** `BCD_DISP_LEADING_ZERO_BLANK_EN`.
  - **Defined:** when `hold_tens` == 0 and the state is `DIG_TENS`, `seg` = 7'h7F (all segments off). `an` still cycles normally, keeping brightness uniform.
  - **Undefined:** a tens value of 0 displays "0" (7'h40).
- **Not affected by the macro:** the ones digit, and invalid-value dash display.

## Structure
- **Package `bcd_disp_pkg`:**
  - State enum (`DIG_ONES`, `DIG_TENS`).
  - Segment constants `SEG_BLANK` = 7'h7F and `SEG_DASH` = 7'h3F.
  - The 10-entry active-low digit pattern table (0: 7'h40 … 9: 7'h10).
  - Anode constants `AN_ONES` = 2'b10 and `AN_TENS` = 2'b01.
- **Sub-module `bcd_to_7seg`:** purely combinational 4-bit → 7-bit decoder, dash for values > 9. Instantiated once and fed by a mux on the current digit.
- **Top level:** the counter, FSM, hold registers and output registers stay in `bcd_7seg_display_mux`.

## Test plan
All scenarios use `REFRESH_DIV` = 4.
- **Reset:** assert `rst` at time 0 → `seg`=7'h40, `an`=2'b10, `frame_tick`=0, `bcd_err`=0 with no clock edge required.
- **Steady digits:** `tens`=1, `ones`=3 held, after the first frame boundary:
  - `DIG_ONES` phase: `seg`=7'h30, `an`=2'b10 for 4 cycles.
  - `DIG_TENS` phase: `seg`=7'h79, `an`=2'b01 for 4 cycles.
  - `frame_tick` pulses every 8 cycles.
- **Mid-frame input change:** set `ones`=5 → `seg` holds 7'h30 during `DIG_ONES`. 7'h12 appears only on the cycle after the next `frame_tick`.
- **Invalid BCD:** `ones`=4'hB, `tens`=1 → `bcd_err`=1 from the frame boundary; `DIG_ONES` `seg`=7'h3F; tens digit still 7'h79. Restoring `ones`=2 clears `bcd_err` at the next boundary.
- **Leading zero:** `tens`=0, `ones`=7 → `DIG_TENS` `seg`=7'h7F with `BCD_DISP_LEADING_ZERO_BLANK_EN` defined, 7'h40 without; `DIG_ONES` `seg`=7'h78 in both builds.
- **Reset mid-frame:** assert `rst` during the `DIG_TENS` phase → all outputs return to reset values asynchronously. After release, the first `frame_tick` occurs exactly 8 cycles later.
